// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between two pipeline stages around one pipe_skid_reg.
// The register itself takes the slave view; the surrounding logic takes the master view.
interface pipe_skid_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic inter-stage pipeline register: main slot plus one skid slot, synchronous flush,
// and a saturating back-pressure counter. All outputs, including in_ready, come from flops.
module pipe_skid_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  pipe_skid_reg_if.slave       bus,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q,     state_d;
  logic                  inReady_q,   inReady_d;
  logic                  mainValid_q, mainValid_d;
  logic [CTRL_WIDTH-1:0] mainCtrl_q,  mainCtrl_d;
  logic [DATA_WIDTH-1:0] mainData_q,  mainData_d;
  logic                  skidValid_q, skidValid_d;
  logic [CTRL_WIDTH-1:0] skidCtrl_q,  skidCtrl_d;
  logic [DATA_WIDTH-1:0] skidData_q,  skidData_d;
  logic [CNT_WIDTH-1:0]  stallCnt_q,  stallCnt_d;

  logic push;
  logic pop;
  logic stalled;

  assign push    = bus.in_valid & inReady_q;
  assign pop     = mainValid_q & bus.out_ready;
  assign stalled = mainValid_q & ~bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      inReady_q   <= 1'b0;
      mainValid_q <= 1'b0;
      mainCtrl_q  <= '0;
      mainData_q  <= '0;
      skidValid_q <= 1'b0;
      skidCtrl_q  <= '0;
      skidData_q  <= '0;
      stallCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      inReady_q   <= inReady_d;
      mainValid_q <= mainValid_d;
      mainCtrl_q  <= mainCtrl_d;
      mainData_q  <= mainData_d;
      skidValid_q <= skidValid_d;
      skidCtrl_q  <= skidCtrl_d;
      skidData_q  <= skidData_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  // Slots that stop holding an entry are zeroed, so a bubble never carries live control bits.
  always_comb begin
    state_d     = state_q;
    mainValid_d = mainValid_q;
    mainCtrl_d  = mainCtrl_q;
    mainData_d  = mainData_q;
    skidValid_d = skidValid_q;
    skidCtrl_d  = skidCtrl_q;
    skidData_d  = skidData_q;

    if (flush) begin
      state_d     = EMPTY;
      mainValid_d = 1'b0;
      mainCtrl_d  = '0;
      mainData_d  = '0;
      skidValid_d = 1'b0;
      skidCtrl_d  = '0;
      skidData_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            mainValid_d = 1'b1;
            mainCtrl_d  = bus.in_ctrl;
            mainData_d  = bus.in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            mainCtrl_d = bus.in_ctrl;
            mainData_d = bus.in_data;
          end else if (push) begin
            state_d     = TWO;
            skidValid_d = 1'b1;
            skidCtrl_d  = bus.in_ctrl;
            skidData_d  = bus.in_data;
          end else if (pop) begin
            state_d     = EMPTY;
            mainValid_d = 1'b0;
            mainCtrl_d  = '0;
            mainData_d  = '0;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            mainCtrl_d  = skidCtrl_q;
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
            skidCtrl_d  = '0;
            skidData_d  = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          mainValid_d = 1'b0;
          mainCtrl_d  = '0;
          mainData_d  = '0;
          skidValid_d = 1'b0;
          skidCtrl_d  = '0;
          skidData_d  = '0;
        end
      endcase
    end

    inReady_d = (state_d != TWO);
  end

  // Counts every cycle the downstream refuses a held entry, flush cycles included.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stalled && (stallCnt_q != CNT_MAX)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = mainValid_q;
  assign bus.out_ctrl  = mainCtrl_q;
  assign bus.out_data  = mainData_q;
  assign stall_cnt     = stallCnt_q;

  aMainBubbleClean: assert property (@(posedge clk) disable iff (!rstn)
    !mainValid_q |-> (mainCtrl_q == '0 && mainData_q == '0));

  aSkidBubbleClean: assert property (@(posedge clk) disable iff (!rstn)
    !skidValid_q |-> (skidCtrl_q == '0 && skidData_q == '0));

  aValidMatchesState: assert property (@(posedge clk) disable iff (!rstn)
    (mainValid_q == (state_q != EMPTY)) && (skidValid_q == (state_q == TWO)));

  aNoPushWhenFull: assert property (@(posedge clk) disable iff (!rstn)
    (state_q == TWO) |-> !inReady_q);

endmodule
